// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - ping-pong frame buffer controller sharing one single-port memory
// Writer and reader alternate between two BUF_SIZE regions; one memory access per cycle.
module frame_buf_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BUF_SIZE   = 500,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [1:0]            buf_full,
    output logic                  frame_wr_done,
    output logic                  frame_rd_done
);
    localparam int CNT_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BUF_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] BUF1_BASE = ADDR_WIDTH'(BUF_SIZE);

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_W-1:0]      rcnt_q, rcnt_d;
    logic [1:0]            full_q, full_d;
    grant_e                last_q, last_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rd_done_q, rd_done_d;
    logic [RD_LAT-1:0]     vld_q, vld_d;

    logic                  wr_elig, rd_elig;
    logic                  grant_w, grant_r;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    // Eligibility looks only at registered flags, so a buffer freed this
    // cycle becomes writable on the next one.
    always_comb begin
        wr_elig = wr_req && !full_q[wb_q];
        rd_elig = rd_req && full_q[rb_q];
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (!reset) begin
            grant_w = wr_elig && (!rd_elig || (last_q == GRANT_RD));
            grant_r = rd_elig && !grant_w;
        end
        wr_addr = (wb_q ? BUF1_BASE : '0) + ADDR_WIDTH'(wcnt_q);
        rd_addr = (rb_q ? BUF1_BASE : '0) + ADDR_WIDTH'(rcnt_q);
    end

    always_comb begin
        wb_d          = wb_q;
        rb_d          = rb_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        full_d        = full_q;
        last_d        = last_q;
        mem_wr_en_d   = grant_w;
        mem_rd_en_d   = grant_r;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        wr_done_d     = 1'b0;
        rd_done_d     = 1'b0;
        vld_d         = (vld_q << 1) | RD_LAT'(mem_rd_en_q);

        if (grant_w) begin
            last_d        = GRANT_WR;
            mem_addr_d    = wr_addr;
            mem_wr_data_d = wr_data;
            if (wcnt_q == CNT_LAST) begin
                wcnt_d         = '0;
                full_d[wb_q]   = 1'b1;
                wb_d           = ~wb_q;
                wr_done_d      = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (grant_r) begin
            last_d     = GRANT_RD;
            mem_addr_d = rd_addr;
            if (rcnt_q == CNT_LAST) begin
                rcnt_d       = '0;
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                rd_done_d    = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q          <= 1'b0;
            rb_q          <= 1'b0;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            full_q        <= 2'b00;
            last_q        <= GRANT_RD;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            vld_q         <= '0;
        end else begin
            wb_q          <= wb_d;
            rb_q          <= rb_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            full_q        <= full_d;
            last_q        <= last_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            wr_done_q     <= wr_done_d;
            rd_done_q     <= rd_done_d;
            vld_q         <= vld_d;
        end
    end

    // Outputs are forced low during reset so a read in flight never reports valid data.
    always_comb begin
        wr_ack        = grant_w;
        rd_ack        = grant_r;
        rd_data       = mem_rd_data;
        rd_data_valid = vld_q[RD_LAT-1] && !reset;
        mem_wr_en     = mem_wr_en_q && !reset;
        mem_rd_en     = mem_rd_en_q && !reset;
        mem_addr      = reset ? '0 : mem_addr_q;
        mem_wr_data   = reset ? '0 : mem_wr_data_q;
        buf_full      = reset ? 2'b00 : full_q;
        frame_wr_done = wr_done_q && !reset;
        frame_rd_done = rd_done_q && !reset;
    end

endmodule
